// File: rtl/window_line_buffer.sv
// window_line_buffer: KxK sliding-window generator over a raster pixel stream.
// K-1 line memories feed a KxK register window; one window per accepted interior pixel.
module window_line_buffer #(
    parameter int DW    = 12,
    parameter int K     = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    output logic [K*K*DW-1:0] out_window,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic              out_eof
);
    localparam int R  = (K - 1) / 2;
    localparam int AW = $clog2(IMG_W);

    logic [9:0]    x_q, y_q, x_d, y_d, x_c, y_c, out_x_q, out_y_q;
    logic          out_valid_q, out_eof_q, last_x, last_y, hit;
    logic [DW-1:0] line_q [K-1][IMG_W];
    logic [DW-1:0] win_q  [K][K];
    logic [DW-1:0] col_c  [K];

    always_comb begin
        x_c    = (in_valid && in_sof) ? '0 : x_q;
        y_c    = (in_valid && in_sof) ? '0 : y_q;
        last_x = x_c == 10'(IMG_W - 1);
        last_y = y_c == 10'(IMG_H - 1);
        x_d    = in_valid ? (last_x ? '0 : x_c + 10'd1) : x_q;
        y_d    = (in_valid && last_x) ? (last_y ? '0 : y_c + 10'd1) : (in_valid ? y_c : y_q);
        hit    = in_valid && x_c >= 10'(K - 1) && y_c >= 10'(K - 1);
        // oldest line on top, live pixel at the bottom
        col_c[K-1] = in_data;
        for (int r = 0; r < K - 1; r++) col_c[r] = line_q[K-2-r][x_c[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            line_q[0][x_c[AW-1:0]] <= in_data;
            for (int i = 1; i < K - 1; i++) line_q[i][x_c[AW-1:0]] <= line_q[i-1][x_c[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int c = 0; c < K; c++)
                for (int r = 0; r < K; r++) win_q[c][r] <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= hit;
            out_eof_q   <= hit && last_x && last_y;
            if (hit) begin
                out_x_q <= x_c - 10'(R);
                out_y_q <= y_c - 10'(R);
            end
            if (in_valid) begin
                for (int c = 0; c < K - 1; c++) win_q[c] <= win_q[c+1];
                win_q[K-1] <= col_c;
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign out_window[(r*K+c)*DW +: DW] = win_q[c][r];
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: directed checks of 3x3 and 5x5 windows on an 8x6 frame.
module tb_window_line_buffer;
    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
    logic [11:0]  in_data = '0;
    logic         v3, e3, v5, e5;
    logic [9:0]   x3, y3, x5, y5;
    logic [107:0] w3;
    logic [299:0] w5;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    window_line_buffer #(.DW(12), .K(3), .IMG_W(8), .IMG_H(6)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_valid(v3), .out_window(w3), .out_x(x3), .out_y(y3), .out_eof(e3));

    window_line_buffer #(.DW(12), .K(5), .IMG_W(8), .IMG_H(6)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_valid(v5), .out_window(w5), .out_x(x5), .out_y(y5), .out_eof(e5));

    // expected window centred at (cx,cy): element (r,c) is pixel (cx-R+c, cy-R+r)
    function automatic logic [299:0] exp_win(input int k, input int cx, input int cy, input logic [11:0] m);
        logic [299:0] w;
        int px, py;
        w = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) begin
                px = cx - (k - 1) / 2 + c;
                py = cy - (k - 1) / 2 + r;
                w[(r*k+c)*12 +: 12] = {4'h0, py[3:0], px[3:0]} ^ m;
            end
        return w;
    endfunction

    // pushes the first npix pixels of a frame, checking both DUTs after every accept
    task automatic run_frame(input int npix, input bit gaps, input bit sof0, input logic [11:0] m,
                             output int nw3, output int ne3, output int nw5, output int ne5);
        int x, y;
        bit ev3, ev5, last;
        logic [299:0] ew;
        nw3 = 0; ne3 = 0; nw5 = 0; ne5 = 0;
        for (int i = 0; i < npix; i++) begin
            x = i % 8;
            y = i / 8;
            in_valid = 1'b1;
            in_sof   = sof0 && i == 0;
            in_data  = {4'h0, y[3:0], x[3:0]} ^ m;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
            ev3  = x >= 2 && y >= 2;
            ev5  = x >= 4 && y >= 4;
            last = x == 7 && y == 5;
            nw3 += int'(v3); ne3 += int'(e3); nw5 += int'(v5); ne5 += int'(e5);
            total++;
            if (v3 !== ev3) begin bad++; $display("FAIL k3_valid px=(%0d,%0d) got %b exp %b", x, y, v3, ev3); end
            total++;
            if (e3 !== (ev3 && last)) begin bad++; $display("FAIL k3_eof px=(%0d,%0d) got %b exp %b", x, y, e3, ev3 && last); end
            total++;
            if (v5 !== ev5) begin bad++; $display("FAIL k5_valid px=(%0d,%0d) got %b exp %b", x, y, v5, ev5); end
            total++;
            if (e5 !== (ev5 && last)) begin bad++; $display("FAIL k5_eof px=(%0d,%0d) got %b exp %b", x, y, e5, ev5 && last); end
            if (ev3) begin
                ew = exp_win(3, x - 1, y - 1, m);
                total++;
                if ({x3, y3} !== {10'(x - 1), 10'(y - 1)})
                    begin bad++; $display("FAIL k3_centre got (%0d,%0d) exp (%0d,%0d)", x3, y3, x - 1, y - 1); end
                total++;
                if (w3 !== ew[107:0]) begin bad++; $display("FAIL k3_window c=(%0d,%0d) got %h exp %h", x - 1, y - 1, w3, ew[107:0]); end
            end
            if (ev5) begin
                ew = exp_win(5, x - 2, y - 2, m);
                total++;
                if ({x5, y5} !== {10'(x - 2), 10'(y - 2)})
                    begin bad++; $display("FAIL k5_centre got (%0d,%0d) exp (%0d,%0d)", x5, y5, x - 2, y - 2); end
                total++;
                if (w5 !== ew) begin bad++; $display("FAIL k5_window c=(%0d,%0d) got %h exp %h", x - 2, y - 2, w5, ew); end
            end
            if (gaps) repeat (2) begin
                @(posedge clk); #1;
                total++;
                if ({v3, e3, v5, e5} !== 4'b0) begin bad++; $display("FAIL gap_idle got %b exp 0000", {v3, e3, v5, e5}); end
            end
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({v3, e3, x3, y3, w3} !== '0) begin bad++; $display("FAIL %s_k3 got v=%b e=%b x=%0d y=%0d w=%h exp all 0", name, v3, e3, x3, y3, w3); end
        total++;
        if ({v5, e5, x5, y5, w5} !== '0) begin bad++; $display("FAIL %s_k5 got v=%b e=%b x=%0d y=%0d w=%h exp all 0", name, v5, e5, x5, y5, w5); end
    endtask

    task automatic check_counts(input string name, input int nw, input int ne, input int enw, input int ene);
        total++;
        if (nw !== enw || ne !== ene) begin bad++; $display("FAIL %s_counts got windows=%0d eof=%0d exp windows=%0d eof=%0d", name, nw, ne, enw, ene); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
    endtask

    task automatic test_continuous();
        int a, b, c, d;
        run_frame(48, 1'b0, 1'b1, 12'h000, a, b, c, d);
        check_counts("continuous", a, b, 24, 1);
    endtask

    task automatic test_gaps();
        int a, b, c, d;
        run_frame(48, 1'b1, 1'b1, 12'h000, a, b, c, d);
        check_counts("gaps", a, b, 24, 1);
    endtask

    task automatic test_sof_restart();
        int a, b, c, d;
        run_frame(29, 1'b0, 1'b1, 12'h800, a, b, c, d);
        run_frame(48, 1'b0, 1'b1, 12'h000, a, b, c, d);
        check_counts("sof_restart", a, b, 24, 1);
    endtask

    task automatic test_reset_mid();
        int a, b, c, d;
        run_frame(36, 1'b0, 1'b1, 12'h800, a, b, c, d);
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_mid");
        reset = 1'b0;
        run_frame(48, 1'b0, 1'b1, 12'h000, a, b, c, d);
        check_counts("reset_mid", a, b, 24, 1);
    endtask

    task automatic test_k5();
        int a, b, c, d;
        run_frame(48, 1'b0, 1'b1, 12'h000, a, b, c, d);
        check_counts("k5", c, d, 8, 1);
    endtask

    task automatic test_back_to_back();
        int a1, b1, c1, d1, a2, b2, c2, d2;
        run_frame(48, 1'b0, 1'b1, 12'h000, a1, b1, c1, d1);
        run_frame(48, 1'b0, 1'b0, 12'h000, a2, b2, c2, d2);
        check_counts("b2b_k3", a1 + a2, b1 + b2, 48, 2);
        check_counts("b2b_k5", c1 + c2, d1 + d2, 16, 2);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_sof_restart();
        test_reset_mid();
        test_k5();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
